// File: rtl/rob_buffer_pkg.sv
// Shared widths and payload types for the reorder buffer slice.
package rob_buffer_pkg;

  // Bus widths of the surrounding pipeline.
  localparam int DATA_BUS_WIDTH     = 32;
  localparam int REG_ADDR_BUS_WIDTH = 5;
  localparam int EXC_TYPE_BUS_WIDTH = 5;

  // Default geometry: 2^4 = 16 entries.
  localparam int ROB_ADDR_WIDTH_DEF = 4;

  // Exception code meaning "no exception detected before the ROB".
  localparam logic [EXC_TYPE_BUS_WIDTH-1:0] EXC_NONE = '0;

  // Per-entry control payload captured at dispatch. The PC and result
  // live in their own arrays because their width is a module parameter.
  typedef struct packed {
    logic                          reg_write_en;
    logic [REG_ADDR_BUS_WIDTH-1:0] reg_write_addr;
    logic [EXC_TYPE_BUS_WIDTH-1:0] exception_type;
    logic                          is_delayslot;
  } rob_ctrl_t;

  // An entry that already carries an exception needs no writeback.
  function automatic logic born_done(input logic [EXC_TYPE_BUS_WIDTH-1:0] exc);
    return exc != EXC_NONE;
  endfunction

endpackage

// File: rtl/rob_pointer.sv
// Wrap-bit pointer: index bits plus one extra MSB that toggles on every
// lap, so equal indices can be told apart as "empty" or "full".
module rob_pointer #(
  parameter int PTR_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [PTR_WIDTH-1:0] ptr_o
);

  logic [PTR_WIDTH-1:0] ptr_q;
  logic [PTR_WIDTH-1:0] ptr_d;

  // Next pointer value: advance by one, wrapping naturally mod 2^PTR_WIDTH.
  always_comb begin
    ptr_d = ptr_q + PTR_WIDTH'(inc_i);
  end

  // Pointer register with synchronous reset and synchronous clear.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_buffer.sv
// Reorder buffer: in-order allocation, out-of-order completion by index,
// in-order retirement on a registered commit port.
module rob_buffer
  import rob_buffer_pkg::*;
#(
  parameter int ROB_ADDR_WIDTH = ROB_ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_BUS_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          dispatch_en,
  input  logic                          dispatch_reg_write_en,
  input  logic [REG_ADDR_BUS_WIDTH-1:0] dispatch_reg_write_addr,
  input  logic [EXC_TYPE_BUS_WIDTH-1:0] dispatch_exception_type,
  input  logic                          dispatch_is_delayslot,
  input  logic [DATA_WIDTH-1:0]         dispatch_pc,
  output logic [ROB_ADDR_WIDTH-1:0]     dispatch_rob_addr,
  output logic                          rob_full,
  output logic                          rob_empty,
  input  logic                          wb_en,
  input  logic [ROB_ADDR_WIDTH-1:0]     wb_rob_addr,
  input  logic [DATA_WIDTH-1:0]         wb_data,
  input  logic                          commit_stall,
  output logic                          commit_en,
  output logic [ROB_ADDR_WIDTH-1:0]     commit_rob_addr,
  output logic                          commit_reg_write_en,
  output logic [REG_ADDR_BUS_WIDTH-1:0] commit_reg_write_addr,
  output logic [DATA_WIDTH-1:0]         commit_data,
  output logic [EXC_TYPE_BUS_WIDTH-1:0] commit_exception_type,
  output logic                          commit_is_delayslot,
  output logic [DATA_WIDTH-1:0]         commit_pc
);

  localparam int DEPTH     = 1 << ROB_ADDR_WIDTH;
  localparam int PTR_WIDTH = ROB_ADDR_WIDTH + 1;

  // Pointers and derived indices.
  logic [PTR_WIDTH-1:0]      head_q;
  logic [PTR_WIDTH-1:0]      tail_q;
  logic [ROB_ADDR_WIDTH-1:0] head_idx;
  logic [ROB_ADDR_WIDTH-1:0] tail_idx;

  // Per-entry status flags.
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] done_q;
  logic [DEPTH-1:0] done_d;

  // Payload storage (no reset needed: valid gates every use).
  rob_ctrl_t             ctrl_mem [DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  // Cycle decisions.
  logic do_dispatch;
  logic wb_hit;
  logic do_retire;

  // Registered commit port.
  logic                          commit_en_q;
  logic [ROB_ADDR_WIDTH-1:0]     commit_rob_addr_q;
  logic                          commit_reg_write_en_q;
  logic [REG_ADDR_BUS_WIDTH-1:0] commit_reg_write_addr_q;
  logic [DATA_WIDTH-1:0]         commit_data_q;
  logic [EXC_TYPE_BUS_WIDTH-1:0] commit_exception_type_q;
  logic                          commit_is_delayslot_q;
  logic [DATA_WIDTH-1:0]         commit_pc_q;

  assign head_idx = head_q[ROB_ADDR_WIDTH-1:0];
  assign tail_idx = tail_q[ROB_ADDR_WIDTH-1:0];

  // Occupancy straight from the registered pointers. Full is therefore the
  // value before this cycle's retire, so a same-cycle retire cannot make
  // room for a same-cycle dispatch.
  assign rob_empty = (head_q == tail_q);
  assign rob_full  = (head_idx == tail_idx) &&
                     (head_q[ROB_ADDR_WIDTH] != tail_q[ROB_ADDR_WIDTH]);
  assign dispatch_rob_addr = tail_idx;

  // Flush dominates every other action in the same cycle. Retire looks only
  // at registered flags, so a writeback is seen one cycle later at the head.
  always_comb begin
    do_dispatch = dispatch_en && !rob_full && !flush;
    wb_hit      = wb_en && valid_q[wb_rob_addr] && !flush;
    do_retire   = valid_q[head_idx] && done_q[head_idx] && !commit_stall && !flush;
  end

  rob_pointer #(.PTR_WIDTH(PTR_WIDTH)) u_head (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .inc_i (do_retire),
    .ptr_o (head_q)
  );

  rob_pointer #(.PTR_WIDTH(PTR_WIDTH)) u_tail (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .inc_i (do_dispatch),
    .ptr_o (tail_q)
  );

  // Next valid/done flags: dispatch allocates, writeback completes, retire
  // frees. Retire is applied last so it wins over a writeback to the head.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (do_dispatch && (tail_idx == ROB_ADDR_WIDTH'(i))) begin
        valid_d[i] = 1'b1;
        done_d[i]  = born_done(dispatch_exception_type);
      end
      if (wb_hit && (wb_rob_addr == ROB_ADDR_WIDTH'(i))) begin
        done_d[i] = 1'b1;
      end
      if (do_retire && (head_idx == ROB_ADDR_WIDTH'(i))) begin
        valid_d[i] = 1'b0;
        done_d[i]  = 1'b0;
      end
    end
  end

  // Status flag registers.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Payload writes. Dispatch targets the tail, which is never valid when a
  // dispatch is accepted, so it cannot collide with an accepted writeback.
  // Result data is zeroed at allocation so exception entries retire with 0.
  always_ff @(posedge clk) begin
    if (do_dispatch) begin
      ctrl_mem[tail_idx] <= '{reg_write_en:   dispatch_reg_write_en,
                              reg_write_addr: dispatch_reg_write_addr,
                              exception_type: dispatch_exception_type,
                              is_delayslot:   dispatch_is_delayslot};
      pc_mem[tail_idx]   <= dispatch_pc;
      data_mem[tail_idx] <= '0;
    end
    if (wb_hit) begin
      data_mem[wb_rob_addr] <= wb_data;
    end
  end

  // Commit port register: carries the retired head entry for one cycle,
  // otherwise all fields are driven to zero.
  always_ff @(posedge clk) begin
    if (rst || flush || !do_retire) begin
      commit_en_q             <= 1'b0;
      commit_rob_addr_q       <= '0;
      commit_reg_write_en_q   <= 1'b0;
      commit_reg_write_addr_q <= '0;
      commit_data_q           <= '0;
      commit_exception_type_q <= '0;
      commit_is_delayslot_q   <= 1'b0;
      commit_pc_q             <= '0;
    end else begin
      commit_en_q             <= 1'b1;
      commit_rob_addr_q       <= head_idx;
      commit_reg_write_en_q   <= ctrl_mem[head_idx].reg_write_en;
      commit_reg_write_addr_q <= ctrl_mem[head_idx].reg_write_addr;
      commit_data_q           <= data_mem[head_idx];
      commit_exception_type_q <= ctrl_mem[head_idx].exception_type;
      commit_is_delayslot_q   <= ctrl_mem[head_idx].is_delayslot;
      commit_pc_q             <= pc_mem[head_idx];
    end
  end

  assign commit_en             = commit_en_q;
  assign commit_rob_addr       = commit_rob_addr_q;
  assign commit_reg_write_en   = commit_reg_write_en_q;
  assign commit_reg_write_addr = commit_reg_write_addr_q;
  assign commit_data           = commit_data_q;
  assign commit_exception_type = commit_exception_type_q;
  assign commit_is_delayslot   = commit_is_delayslot_q;
  assign commit_pc             = commit_pc_q;

endmodule

// File: tb/tb_rob_buffer.sv
// Directed plus randomized bench for rob_buffer against a queue-based model.
module tb_rob_buffer;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        dispatch_en, dispatch_reg_write_en, dispatch_is_delayslot;
  logic [4:0]  dispatch_reg_write_addr, dispatch_exception_type;
  logic [31:0] dispatch_pc;
  logic [3:0]  dispatch_rob_addr;
  logic        rob_full, rob_empty;
  logic        wb_en;
  logic [3:0]  wb_rob_addr;
  logic [31:0] wb_data;
  logic        commit_stall;
  logic        commit_en, commit_reg_write_en, commit_is_delayslot;
  logic [3:0]  commit_rob_addr;
  logic [4:0]  commit_reg_write_addr, commit_exception_type;
  logic [31:0] commit_data, commit_pc;

  always #5 clk = ~clk;

  rob_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_en(dispatch_en),
    .dispatch_reg_write_en(dispatch_reg_write_en),
    .dispatch_reg_write_addr(dispatch_reg_write_addr),
    .dispatch_exception_type(dispatch_exception_type),
    .dispatch_is_delayslot(dispatch_is_delayslot),
    .dispatch_pc(dispatch_pc),
    .dispatch_rob_addr(dispatch_rob_addr),
    .rob_full(rob_full), .rob_empty(rob_empty),
    .wb_en(wb_en), .wb_rob_addr(wb_rob_addr), .wb_data(wb_data),
    .commit_stall(commit_stall),
    .commit_en(commit_en), .commit_rob_addr(commit_rob_addr),
    .commit_reg_write_en(commit_reg_write_en),
    .commit_reg_write_addr(commit_reg_write_addr),
    .commit_data(commit_data),
    .commit_exception_type(commit_exception_type),
    .commit_is_delayslot(commit_is_delayslot),
    .commit_pc(commit_pc)
  );

  // Model: program-ordered list of in-flight instructions.
  typedef struct {
    int          seq;      // allocation count mod 32 (index + lap bit)
    logic        rwe;
    logic [4:0]  rwa;
    logic [4:0]  exc;
    logic        ds;
    logic [31:0] pc;
    logic        done;
    logic        wrote;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   alloc_cnt;         // next allocation number, mod 32
  ent_t exp_c;             // entry expected on the commit port
  logic exp_cen;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge of spec behaviour to the model, using the inputs
  // currently being driven.
  task automatic model_step();
    bit was_full;
    exp_cen = 1'b0;
    if (rst || flush) begin
      q.delete();
      alloc_cnt = 0;
      return;
    end
    was_full = (q.size() == 16);
    if (q.size() > 0 && q[0].done && !commit_stall) begin
      exp_c   = q.pop_front();
      exp_cen = 1'b1;
    end
    if (wb_en) begin
      foreach (q[i]) begin
        if (q[i].seq % 16 == int'(wb_rob_addr)) begin
          q[i].done  = 1'b1;
          q[i].wrote = 1'b1;
          q[i].data  = wb_data;
        end
      end
    end
    if (dispatch_en && !was_full) begin
      ent_t e;
      e.seq = alloc_cnt; e.rwe = dispatch_reg_write_en; e.rwa = dispatch_reg_write_addr;
      e.exc = dispatch_exception_type; e.ds = dispatch_is_delayslot; e.pc = dispatch_pc;
      e.done = (dispatch_exception_type != 0); e.wrote = 1'b0; e.data = 0;
      q.push_back(e);
      alloc_cnt = (alloc_cnt + 1) % 32;
    end
  endtask

  task automatic check_outputs();
    check("rob_empty", 64'(rob_empty), 64'(q.size() == 0));
    check("rob_full", 64'(rob_full), 64'(q.size() == 16));
    check("dispatch_rob_addr", 64'(dispatch_rob_addr), 64'(alloc_cnt % 16));
    check("commit_en", 64'(commit_en), 64'(exp_cen));
    if (exp_cen) begin
      $display("commit idx=%0d pc=%h data=%h exc=%0d", commit_rob_addr, commit_pc, commit_data, commit_exception_type);
      check("commit_rob_addr", 64'(commit_rob_addr), 64'(exp_c.seq % 16));
      check("commit_rwe", 64'(commit_reg_write_en), 64'(exp_c.rwe));
      check("commit_rwa", 64'(commit_reg_write_addr), 64'(exp_c.rwa));
      check("commit_exc", 64'(commit_exception_type), 64'(exp_c.exc));
      check("commit_ds", 64'(commit_is_delayslot), 64'(exp_c.ds));
      check("commit_pc", 64'(commit_pc), 64'(exp_c.pc));
      if (exp_c.wrote) check("commit_data", 64'(commit_data), 64'(exp_c.data));
    end else begin
      check("commit_idle_fields", {commit_rob_addr, commit_reg_write_en, commit_reg_write_addr,
            commit_exception_type, commit_is_delayslot, commit_pc != 0, commit_data != 0}, 64'd0);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    flush = 0; dispatch_en = 0; dispatch_reg_write_en = 0; dispatch_reg_write_addr = 0;
    dispatch_exception_type = 0; dispatch_is_delayslot = 0; dispatch_pc = 0;
    wb_en = 0; wb_rob_addr = 0; wb_data = 0; commit_stall = 0;
  endtask

  task automatic disp(input logic [31:0] pc, input logic [4:0] exc);
    dispatch_en = 1; dispatch_pc = pc; dispatch_exception_type = exc;
    dispatch_reg_write_en = 1; dispatch_reg_write_addr = pc[6:2]; dispatch_is_delayslot = pc[2];
  endtask

  task automatic wb(input logic [3:0] idx, input logic [31:0] d);
    wb_en = 1; wb_rob_addr = idx; wb_data = d;
  endtask

  initial begin
    idle();
    rst = 1; alloc_cnt = 0; exp_cen = 0;
    @(negedge clk);
    tick();
    rst = 0;
    tick();
    check("reset_empty", 64'(rob_empty), 64'd1);

    // Three dispatches get indices 0, 1, 2.
    for (int i = 0; i < 3; i++) begin
      disp(32'h100 + 32'(4 * i), 0);
      check("alloc_idx", 64'(dispatch_rob_addr), 64'(i));
      tick();
    end
    idle();
    check("not_empty", 64'(rob_empty), 64'd0);

    // Out-of-order completion, in-order retirement; idx 2 stays pending.
    wb(1, 32'hA); tick();
    wb(0, 32'hB); tick();
    idle();
    for (int i = 0; i < 4; i++) tick();
    check("idx2_held", 64'(rob_empty), 64'd0);

    // Fill to 16, drop the 17th, then free one slot and wrap.
    flush = 1; tick(); idle();
    for (int i = 0; i < 16; i++) begin disp(32'h400 + 32'(4 * i), 0); tick(); end
    check("full_after_16", 64'(rob_full), 64'd1);
    disp(32'h500, 0); tick();
    check("tail_unchanged", 64'(dispatch_rob_addr), 64'd0);
    idle();
    wb(0, 32'h55); tick(); idle();
    tick(); tick();
    check("not_full_after_retire", 64'(rob_full), 64'd0);
    disp(32'h600, 0);
    check("wrap_idx", 64'(dispatch_rob_addr), 64'd0);
    tick(); idle();

    // Exception entry retires without a writeback.
    flush = 1; tick(); idle();
    disp(32'h200, 5'd1); tick(); idle();
    tick();
    check("exc_commit_en", 64'(commit_en), 64'd1);
    check("exc_commit_type", 64'(commit_exception_type), 64'd1);
    check("exc_commit_pc", 64'(commit_pc), 64'h200);

    // Commit stall holds a done head for five cycles.
    disp(32'h300, 0); tick(); idle();
    wb(4'(alloc_cnt - 1), 32'h77); commit_stall = 1; tick();
    wb_en = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_no_commit", 64'(commit_en), 64'd0);
    end
    commit_stall = 0; tick();
    check("release_commit", 64'(commit_en), 64'd1);
    idle();

    // Flush collides with dispatch and writeback while 4 entries are valid.
    for (int i = 0; i < 4; i++) begin disp(32'h700 + 32'(4 * i), 0); tick(); end
    flush = 1; disp(32'h800, 0); wb(4'(alloc_cnt - 1), 32'h99); tick(); idle();
    check("flush_empty", 64'(rob_empty), 64'd1);
    check("flush_no_commit", 64'(commit_en), 64'd0);
    check("flush_next_idx", 64'(dispatch_rob_addr), 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      idle();
      if ($urandom_range(0, 99) < 70) disp($urandom, ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0);
      if ($urandom_range(0, 99) < 60) begin
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          wb(4'(q[$urandom_range(0, q.size() - 1)].seq), $urandom);
        else
          wb(4'($urandom), $urandom);
      end
      commit_stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 99) < 2);
      tick();
    end
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
